mem_responder: RTL and testbench

- Memory-side responder for the multicycle RV32I datapath's memory port.
- Serves the control unit's mem_read/mem_write requests, with mem_byte_enable, from an internal word-organised array.
- Returns data on mem_rdata and signals completion with a one-cycle mem_resp pulse after a configurable latency.
- Used as the cpu's backing memory in simulation and as the reference responder for cache and arbiter blocks.

---
 rtl/mem_responder_pkg.sv | 27 ++
 rtl/lfsr8.sv | 35 +++
 rtl/mem_responder.sv | 157 +++++++++++++++
 tb/tb_mem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_pkg
// Brief    : Shared types and constants for the mem_responder memory model.
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        is_write;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module   : lfsr8
// Brief    : 8-bit Fibonacci LFSR, advances one step per enable cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [7:0] out
);
    import mem_responder_pkg::*;

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Word-organised memory responder with fixed request latency.
//            Define MEM_RESPONDER_RAND_LATENCY_EN to add 0..7 LFSR-driven
//            extra cycles per request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int WORDS         = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);
    import mem_responder_pkg::*;

    localparam int IDX_W   = $clog2(WORDS);
    localparam int MAX_LAT = ((READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY) + 7;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      mem_array [WORDS];

    logic [IDX_W-1:0] in_idx, req_idx;
    logic             accept, strobe_held, commit;
    logic [2:0]       lat_extra;
    int               lat_load;
    logic             unused_addr;

    assign in_idx      = mem_address[IDX_W+1:2];
    assign req_idx     = req_q.addr[IDX_W+1:2];
    assign accept      = (state_q == IDLE) && (mem_read ^ mem_write);
    assign strobe_held = req_q.is_write ? mem_write : mem_read;
    assign commit      = (state_q == RESP) && req_q.is_write;
    assign unused_addr = ^{mem_address[31:IDX_W+2], mem_address[1:0],
                           req_q.addr[31:IDX_W+2], req_q.addr[1:0]};

`ifdef MEM_RESPONDER_RAND_LATENCY_EN
    logic [7:0] lfsr_out;
    logic       unused_lfsr;

    lfsr8 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (accept),
        .out    (lfsr_out)
    );

    assign lat_extra   = lfsr_out[2:0];
    assign unused_lfsr = ^lfsr_out[7:3];
`else
    assign lat_extra = 3'd0;
`endif

    // Counter holds the number of BUSY cycles still to run before RESP
    always_comb begin
        lat_load = (mem_write ? WRITE_LATENCY : READ_LATENCY) + int'(lat_extra) - 1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end else if (accept) begin
                    req_d.addr     = mem_address;
                    req_d.wdata    = mem_wdata;
                    req_d.be       = mem_byte_enable;
                    req_d.is_write = mem_write;
                    cnt_d          = CNT_W'(lat_load);
                    if (lat_load == 0) begin
                        state_d = RESP;
                        if (!mem_write) begin
                            rdata_d = mem_array[in_idx];
                        end
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!strobe_held) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                        if (!req_q.is_write) begin
                            rdata_d = mem_array[req_idx];
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; reset forces IDLE so no commit occurs
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (req_q.be[b]) begin
                    mem_array[req_idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_resp  = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign proto_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Self-checking bench for mem_responder with a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int WORDS  = 1024;
    localparam int RL     = 2;
    localparam int WL     = 1;
    localparam int BUDGET = RL + WL + 16;
`ifdef MEM_RESPONDER_RAND_LATENCY_EN
    localparam int SLACK = 7;
`else
    localparam int SLACK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        proto_err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [int];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mem_responder #(
        .WORDS         (WORDS),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .proto_err       (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int lat, input int base);
        logic in_win;
        in_win = (lat >= base) && (lat <= base + SLACK);
        check($sformatf("%s lat=%0d base=%0d", tag, lat, base), {31'd0, in_win}, 32'd1);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 2) % WORDS;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // One initiator transaction; returns observed latency (-1 on timeout)
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, output int lat, output logic [31:0] rd);
        @(posedge clk); #1;
        mem_read        = !wr;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wd;
        mem_byte_enable = be;
        lat = -1;
        rd  = 'x;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (mem_resp) begin
                lat = k;
                rd  = mem_rdata;
                break;
            end
            if (k >= 1) begin
                mem_address     = $urandom;
                mem_wdata       = $urandom;
                mem_byte_enable = 4'($urandom);
            end
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check("resp_single", {31'd0, mem_resp}, 32'd0);
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        int          lat;
        logic [31:0] rd;
        int          i;
        i = widx(addr);
        do_req(1'b1, addr, wd, be, lat, rd);
        check_lat("wr_lat", lat, WL);
        check("wr_rdata_hold", rd, last_rd);
        if (model.exists(i)) model[i] = merge(model[i], wd, be);
        else if (be == 4'hF) model[i] = wd;
    endtask

    task automatic rd_word(input logic [31:0] addr, output logic [31:0] rd);
        int lat;
        int i;
        i = widx(addr);
        do_req(1'b0, addr, $urandom, 4'($urandom), lat, rd);
        check_lat("rd_lat", lat, RL);
        if (model.exists(i)) check($sformatf("rd_data@%08h", addr), rd, model[i]);
        if (lat >= 0) last_rd = rd;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("rst_resp", {31'd0, mem_resp}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_err", {31'd0, proto_err}, 32'd0);
        @(posedge clk); #1;
        rst     = 1'b1;
        last_rd = 32'h0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic        seen;
        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'h0;
        mem_wdata       = 32'h0;
        mem_byte_enable = 4'h0;
        last_rd         = 32'h0;
        apply_reset();

        wr_word(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        rd_word(32'h0000_0010, d);
        check("roundtrip", d, 32'hDEAD_BEEF);

        wr_word(32'h0000_0020, 32'h1122_3344, 4'hF);
        rd_word(32'h0000_0020, d);
        check("merge0", d, 32'h1122_3344);
        wr_word(32'h0000_0020, 32'hAABB_CCDD, 4'b0001);
        rd_word(32'h0000_0020, d);
        check("merge1", d, 32'h1122_33DD);
        wr_word(32'h0000_0020, 32'h0000_EEFF, 4'b0011);
        rd_word(32'h0000_0020, d);
        check("merge2", d, 32'h1122_EEFF);
        wr_word(32'h0000_0020, 32'hFFFF_FFFF, 4'b0000);
        rd_word(32'h0000_0020, d);
        check("be_zero", d, 32'h1122_EEFF);

        wr_word(32'h0000_0004, 32'hCAFE_F00D, 4'hF);
        rd_word(32'h0000_1007, d);
        check("alias", d, 32'hCAFE_F00D);

        // Both strobes together must never be accepted
        @(posedge clk); #1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        seen      = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | mem_resp;
        end
        check("both_no_resp", {31'd0, seen}, 32'd0);
        check("both_err", {31'd0, proto_err}, 32'd1);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rd_word(32'h0000_0010, d);
        check("err_sticky", {31'd0, proto_err}, 32'd1);
        apply_reset();

        // Strobe dropped while the read is still in flight
        @(posedge clk); #1;
        mem_read    = 1'b1;
        mem_address = 32'h0000_0010;
        @(posedge clk); #1;
        mem_read = 1'b0;
        seen     = 1'b0;
        repeat (RL + SLACK + 3) begin
            @(negedge clk);
            seen = seen | mem_resp;
        end
        check("drop_no_resp", {31'd0, seen}, 32'd0);
        check("drop_err", {31'd0, proto_err}, 32'd1);
        rd_word(32'h0000_0010, d);
        check("drop_data", d, 32'hDEAD_BEEF);
        apply_reset();

        // Reset asserted in the BUSY cycle of a read
        rd_word(32'h0000_0010, d);
        @(posedge clk); #1;
        mem_read    = 1'b1;
        mem_address = 32'h0000_0004;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_resp", {31'd0, mem_resp}, 32'd0);
        check("midrst_rdata", mem_rdata, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        last_rd  = 32'h0;
        rd_word(32'h0000_0004, d);
        check("post_rst", d, 32'hCAFE_F00D);

        for (int i = 0; i < 16; i++) begin
            wr_word(32'((100 + i) << 2), $urandom, 4'hF);
        end
        for (int n = 0; n < 200; n++) begin
            a = (32'($urandom_range(100, 115)) << 2) | (32'($urandom_range(0, 7)) << 12)
                | 32'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if ($urandom_range(0, 9) < 3) wr_word(a, $urandom, 4'($urandom));
            else rd_word(a, d);
        end
        check("final_err", {31'd0, proto_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
